alu_ctrl_muldiv: RTL

Second-generation ALU control for the RISC-V core: it keeps the combinational funct3/funct7 → ALU-select and branch-code decode and adds a parametrised, iterative M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits between the main control unit and the ALU/writeback mux. The control FSM uses `in_ready`/`out_valid` to stall for multi-cycle multiply/divide operations.

---
 rtl/alu_ctrl_muldiv.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus an iterative RV32M multiply/divide sequencer.
// Decode is purely combinational; mul/div runs one bit per cycle on operand magnitudes.
module alu_ctrl_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      funct3,
    input  logic            funct7_30,
    input  logic            funct7_25,
    input  logic [1:0]      alu_op,
    input  logic            in_valid,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            out_ready,
    output logic [3:0]      alu_op_res,
    output logic [2:0]      branch,
    output logic            md_sel,
    output logic            in_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] md_result
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_div;
    logic [2*XLEN-1:0] r_acc;
    logic              r_qneg;
    logic              r_rneg;

    logic              w_accept, w_sgn_a, w_sgn_b, w_a_neg, w_b_neg;
    logic              w_is_div, w_div0, w_ovf, w_q_bit;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_rem_diff, w_rem_new, w_fin;
    logic [XLEN:0]     w_mul_sum, w_rem_sh;
    logic [2*XLEN-1:0] w_prod;

    function automatic logic [XLEN-1:0] f_neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v) + XLEN'(1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_neg2_if(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? (~v) + (2*XLEN)'(1) : v;
    endfunction

    always_comb begin
        alu_op_res = 4'b0010;
        branch     = 3'b000;
        md_sel     = 1'b0;
        case (alu_op)
            2'b11: branch = 3'b010;
            2'b01: begin
                alu_op_res = 4'b0110;
                branch     = funct3;
            end
            2'b00: begin
                case (funct3)
                    3'b001:  alu_op_res = 4'b1100;
                    3'b100:  alu_op_res = 4'b0011;
                    3'b101:  alu_op_res = 4'b1101;
                    3'b110:  alu_op_res = 4'b0001;
                    3'b111:  alu_op_res = 4'b0000;
                    default: alu_op_res = 4'b0010;
                endcase
            end
            default: begin
                if (funct7_25) begin
                    md_sel     = 1'b1;
                    alu_op_res = 4'b1111;
                end else begin
                    case ({funct7_30, funct3})
                        4'b0001: alu_op_res = 4'b0100;
                        4'b1000: alu_op_res = 4'b0110;
                        4'b0100: alu_op_res = 4'b0011;
                        4'b0101: alu_op_res = 4'b0101;
                        4'b0110: alu_op_res = 4'b0001;
                        4'b0111: alu_op_res = 4'b0000;
                        default: alu_op_res = 4'b0010;
                    endcase
                end
            end
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid & md_sel & in_ready;

    // MULH/MULHSU/DIV/REM treat op_a as signed; only MULH/DIV/REM treat op_b as signed
    assign w_sgn_a  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sgn_b  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg  = w_sgn_a & op_a[XLEN-1];
    assign w_b_neg  = w_sgn_b & op_b[XLEN-1];
    assign w_mag_a  = f_neg_if(w_a_neg, op_a);
    assign w_mag_b  = f_neg_if(w_b_neg, op_b);
    assign w_is_div = funct3[2];
    assign w_div0   = (op_b == '0);
    assign w_ovf    = ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_div} : '0);
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_diff = w_rem_sh[XLEN-1:0] - r_div;
    assign w_rem_new  = w_q_bit ? w_rem_diff : w_rem_sh[XLEN-1:0];
    assign w_prod     = f_neg2_if(r_qneg, r_acc);

    always_comb begin
        case (r_f3)
            3'b000:         w_fin = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_fin = f_neg_if(r_qneg, r_acc[XLEN-1:0]);
            3'b110, 3'b111: w_fin = f_neg_if(r_rneg, r_acc[2*XLEN-1:XLEN]);
            default:        w_fin = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_div     <= '0;
            r_acc     <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            md_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f3   <= funct3;
                        r_qneg <= w_a_neg ^ w_b_neg;
                        r_rneg <= w_a_neg;
                        r_cnt  <= CNT_W'(XLEN);
                        r_div  <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        if (w_is_div && w_div0) begin
                            md_result <= funct3[1] ? op_a : '1;
                            r_state   <= S_DONE;
                        end else if (w_is_div && w_ovf) begin
                            md_result <= funct3[1] ? '0 : op_a;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= w_is_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        md_result <= w_fin;
                        r_state   <= S_DONE;
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (r_cnt == '0) begin
                        md_result <= w_fin;
                        r_state   <= S_DONE;
                    end else begin
                        r_acc <= {w_rem_new, r_acc[XLEN-2:0], w_q_bit};
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
